// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display driver.
//   conv_state_t : state encoding of the sequential binary-to-BCD engine
//   SEG_BLANK    : active-low segment pattern with every segment off
//   seg7_decode  : 4-bit BCD digit -> 7-bit active-low {g,f,e,d,c,b,a};
//                  codes above 9 decode to SEG_BLANK
package display_pkg;

  // The load step happens on the edge that leaves ST_IDLE, so it needs no
  // state of its own.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    logic [6:0] segs;
    case (digit)
      4'd0:    segs = 7'b1000000;
      4'd1:    segs = 7'b1111001;
      4'd2:    segs = 7'b0100100;
      4'd3:    segs = 7'b0110000;
      4'd4:    segs = 7'b0011001;
      4'd5:    segs = 7'b0010010;
      4'd6:    segs = 7'b0000010;
      4'd7:    segs = 7'b1111000;
      4'd8:    segs = 7'b0000000;
      4'd9:    segs = 7'b0010000;
      default: segs = SEG_BLANK;
    endcase
    return segs;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double dabble) converter, 12-bit binary -> 4 BCD digits.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset; aborts any conversion in flight
//   start : accepted only while idle (busy low); loads bin on that edge
//   bin   : 12-bit binary operand
//   bcd   : committed result {thousands,hundreds,tens,units}, updated atomically
//   busy  : high from the load edge until the commit edge (13 cycles)
//   done  : one-cycle pulse following the commit edge
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] bin,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        done
);

  conv_state_t state;
  logic [27:0] shift_reg;
  logic [3:0]  bit_cnt;
  logic [27:0] adjusted;

  // Add 3 to every BCD nibble that is 5 or more before the next shift.
  always_comb begin
    adjusted = shift_reg;
    for (int unsigned i = 0; i < 4; i++) begin
      if (shift_reg[12 + 4*i +: 4] >= 4'd5)
        adjusted[12 + 4*i +: 4] = shift_reg[12 + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      bcd       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shift_reg <= {16'h0000, bin};
            bit_cnt   <= 4'd11;
            busy      <= 1'b1;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_reg <= {adjusted[26:0], 1'b0};
          if (bit_cnt == 4'd0)
            state <= ST_COMMIT;
          else
            bit_cnt <= bit_cnt - 4'd1;
        end
        ST_COMMIT: begin
          bcd   <= shift_reg[27:12];
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg_display_driver.sv
// Output end of the keypad-adder datapath: converts the 12-bit sum to BCD and
// drives a 4-digit multiplexed common-anode 7-segment display.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   value : binary value to display
//   an    : digit enables, active-low one-hot, an[0] = units
//   seg   : segments {g,f,e,d,c,b,a}, active-low
//   dp    : decimal point, active-low, held off
//   bcd   : committed BCD digits {thousands,hundreds,tens,units}
//   busy  : conversion in progress
// Parameters: REFRESH_DIV (cycles each digit is lit, >=2), NDIG (fixed at 4).
// Build option: define LEADING_ZERO_BLANK_EN to blank zeros above the most
// significant nonzero digit (units digit is always shown).
module seg_display_driver
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned NDIG        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] value,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [15:0] bcd,
  output logic        busy
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [11:0]   shown_val;
  logic          start;
  logic          conv_done_unused;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    dig_idx;
  logic [3:0]    cur_nibble;
  logic [6:0]    digit_seg;

  // No strobe: any difference from the last accepted value restarts the
  // engine once it is idle, so the latest value is always converted last.
  assign start = !busy && (value != shown_val);

  always_ff @(posedge clk) begin
    if (rst)
      shown_val <= '0;
    else if (start)
      shown_val <= value;
  end

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (value),
    .bcd   (bcd),
    .busy  (busy),
    .done  (conv_done_unused)
  );

  assign cur_nibble = bcd[{dig_idx, 2'b00} +: 4];

  always_comb begin
    digit_seg = seg7_decode(cur_nibble);
`ifdef LEADING_ZERO_BLANK_EN
    if (dig_idx != 2'd0 && (bcd >> {dig_idx, 2'b00}) == 16'h0000)
      digit_seg = SEG_BLANK;
`endif
  end

  // an and seg are registered together from the same index so the enable
  // and its pattern always change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      dig_idx     <= '0;
      an          <= 4'b1111;
      seg         <= SEG_BLANK;
    end else begin
      if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        dig_idx     <= (dig_idx == 2'(NDIG - 1)) ? 2'd0 : dig_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      an  <= ~(4'b0001 << dig_idx);
      seg <= digit_seg;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_seg_display_driver.sv
module tb_seg_display_driver;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] value = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] bcd;
  logic        busy;

  int checks = 0;
  int failures = 0;

  // model state
  int         m_shown = 0, m_pending = 0, m_rem = 0, m_disp = 0, m_k = 0;
  bit         m_busy = 0;
  bit         m_valid = 0;
  logic [3:0] e_an = 4'hF;
  logic [6:0] e_seg = 7'h7F;

  seg_display_driver #(.REFRESH_DIV(R), .NDIG(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .an    (an),
    .seg   (seg),
    .dp    (dp),
    .bcd   (bcd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [6:0] digit_pattern(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int num, input int idx);
    int p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && num < p) return 7'h7F;
`endif
    return digit_pattern((num / p) % 10);
  endfunction

  // Behavioural model: a conversion commits 13 edges after it is accepted;
  // the display shows the committed number, digit (k/R)%4 on the k-th
  // post-reset edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        e_an = 4'hF; e_seg = 7'h7F;
        m_k = 0; m_shown = 0; m_rem = 0; m_busy = 0; m_disp = 0;
      end else begin
        int idx;
        idx = (m_k / R) % 4;
        e_an = ~(4'b0001 << idx);
        e_seg = exp_seg(m_disp, idx);
        m_k++;
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) begin
            m_disp = m_pending;
            m_busy = 0;
          end
        end else if (int'(value) != m_shown) begin
          m_shown = int'(value);
          m_pending = int'(value);
          m_rem = 13;
          m_busy = 1;
        end
      end
      m_valid = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("model_an", 32'(an), 32'(e_an));
        check("model_seg", 32'(seg), 32'(e_seg));
        check("model_dp", 32'(dp), 32'd1);
        check("model_bcd", 32'(bcd), 32'(to_bcd(m_disp)));
        check("model_busy", 32'(busy), 32'(m_busy));
      end
    end
  end

  // Wait (bounded) until the units digit is enabled.
  task automatic sync_units();
    int n = 0;
    while (an !== 4'b1110 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("sync_units", 32'(an === 4'b1110), 32'd1);
  endtask

  task automatic scan_check(input string name, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] exp_s [4];
    exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2; exp_s[3] = s3;
    sync_units();
    for (int d = 0; d < 4; d++) begin
      check({name, "_an"}, 32'(an), 32'(~(4'b0001 << d) & 4'hF));
      check({name, "_seg"}, 32'(seg), 32'(exp_s[d]));
      repeat (R) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    value = '0;
    repeat (3) begin
      @(negedge clk);
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_bcd", 32'(bcd), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
    end
    rst = 1'b0;
    value = 12'd1234;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i <= 13) check("busy_1234", 32'(busy), 32'd1);
      if (i == 13) check("bcd_pre_commit", 32'(bcd), 32'h0);
      if (i == 14) begin
        check("busy_done_1234", 32'(busy), 32'd0);
        check("bcd_1234", 32'(bcd), 32'h1234);
      end
    end
    repeat (2) @(negedge clk);
    scan_check("scan_1234", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

    value = 12'd4095;
    repeat (16) @(negedge clk);
    check("bcd_4095", 32'(bcd), 32'h4095);
    value = 12'd0;
    repeat (16) @(negedge clk);
    check("bcd_0", 32'(bcd), 32'h0000);

    value = 12'd100;
    for (int n = 1; n <= 28; n++) begin
      @(negedge clk);
      if (n == 3) value = 12'd250;
      if (n == 14) check("bcd_100_first", 32'(bcd), 32'h0100);
      if (n == 27) check("bcd_100_held", 32'(bcd), 32'h0100);
      if (n == 28) check("bcd_250", 32'(bcd), 32'h0250);
    end

    value = 12'd7;
    repeat (16) @(negedge clk);
    check("bcd_7", 32'(bcd), 32'h0007);
`ifdef LEADING_ZERO_BLANK_EN
    scan_check("scan_7", 7'b1111000, 7'h7F, 7'h7F, 7'h7F);
`else
    scan_check("scan_7", 7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000);
`endif

    // reset in the middle of a conversion discards it
    value = 12'd555;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_bcd", 32'(bcd), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    repeat (16) @(negedge clk);
    check("bcd_555", 32'(bcd), 32'h0555);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
